alu_op_sequencer: RTL and testbench

//  Registered successor to the EX-stage ALU control decode. Maps (alu_op, funct) to the ALU

---
 rtl/alu_ctrl_pkg.sv | 56 +++++
 rtl/alu_op_decode.sv | 46 ++++
 rtl/alu_op_sequencer.sv | 105 ++++++++++
 tb/tb_alu_op_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the EX-stage ALU control path: op classes, ALU control codes,
// R-type funct codes and the sequencer state type.
package alu_ctrl_pkg;

    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SUB     = 3'b001;
    localparam logic [2:0] OP_AND     = 3'b010;
    localparam logic [2:0] OP_OR      = 3'b011;
    localparam logic [2:0] OP_XOR     = 3'b100;
    localparam logic [2:0] OP_SLT     = 3'b101;
    localparam logic [2:0] OP_FUNCT   = 3'b110;
    localparam logic [2:0] OP_SHORT_B = 3'b111;

    localparam logic [5:0] CTRL_ADD     = 6'b100000;
    localparam logic [5:0] CTRL_SUB     = 6'b100010;
    localparam logic [5:0] CTRL_AND     = 6'b100100;
    localparam logic [5:0] CTRL_OR      = 6'b100101;
    localparam logic [5:0] CTRL_XOR     = 6'b100110;
    localparam logic [5:0] CTRL_SLT     = 6'b101010;
    localparam logic [5:0] CTRL_SHORT_B = 6'b001001;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // MULT/MULTU/DIV/DIVU share funct[5:2]; funct[1] selects divide.
    localparam logic [3:0] FN_MULDIV_HI = 4'b0110;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_MULDIV = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

    function automatic logic funct_legal(input logic [5:0] fn);
        case (fn)
            FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
            FN_XOR, FN_NOR, FN_SLT, FN_SLTU: funct_legal = 1'b1;
            default:                         funct_legal = (fn[5:2] == FN_MULDIV_HI);
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational (alu_op, funct) -> ALU control decode with mult/div detection.
// ALU_SEQ_ILLEGAL_TRAP_EN enables the undefined-op/funct flag; otherwise illegal is 0.
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_BUS_WIDTH  = 6,
    parameter int ALU_OP_BUS_WIDTH    = 3,
    parameter int ALU_FUNCT_BUS_WIDTH = 6
) (
    input  logic [ALU_OP_BUS_WIDTH-1:0]    alu_op,
    input  logic [ALU_FUNCT_BUS_WIDTH-1:0] funct,
    output logic [ALU_CTRL_BUS_WIDTH-1:0]  ctrl,
    output logic                           is_muldiv,
    output logic                           illegal
);

    logic       op_in_range;
    logic [2:0] op_class;

    always_comb begin
        op_in_range = ((alu_op >> 3) == '0);
        op_class    = alu_op[2:0];
        ctrl        = '0;
        is_muldiv   = 1'b0;
        illegal     = 1'b0;
        if (op_in_range) begin
            case (op_class)
                OP_ADD:     ctrl = ALU_CTRL_BUS_WIDTH'(CTRL_ADD);
                OP_SUB:     ctrl = ALU_CTRL_BUS_WIDTH'(CTRL_SUB);
                OP_AND:     ctrl = ALU_CTRL_BUS_WIDTH'(CTRL_AND);
                OP_OR:      ctrl = ALU_CTRL_BUS_WIDTH'(CTRL_OR);
                OP_XOR:     ctrl = ALU_CTRL_BUS_WIDTH'(CTRL_XOR);
                OP_SLT:     ctrl = ALU_CTRL_BUS_WIDTH'(CTRL_SLT);
                OP_FUNCT: begin
                    ctrl      = ALU_CTRL_BUS_WIDTH'(funct);
                    is_muldiv = (funct[5:2] == FN_MULDIV_HI);
                end
                default:    ctrl = ALU_CTRL_BUS_WIDTH'(CTRL_SHORT_B);
            endcase
        end
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        illegal = !op_in_range || ((op_class == OP_FUNCT) && !funct_legal(funct[5:0]));
`endif
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered ALU control decode with a busy/stall sequencer for multi-cycle MULT/DIV ops.
// Illegal-op trapping follows ALU_SEQ_ILLEGAL_TRAP_EN inside alu_op_decode (o_illegal stays 0 without it).
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_BUS_WIDTH  = 6,
    parameter int ALU_OP_BUS_WIDTH    = 3,
    parameter int ALU_FUNCT_BUS_WIDTH = 6,
    parameter int MULT_LATENCY        = 4,
    parameter int DIV_LATENCY         = 32
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_valid,
    input  logic                           i_flush,
    input  logic [ALU_OP_BUS_WIDTH-1:0]    i_alu_op,
    input  logic [ALU_FUNCT_BUS_WIDTH-1:0] i_funct,
    output logic [ALU_CTRL_BUS_WIDTH-1:0]  o_alu_ctrl,
    output logic                           o_valid,
    output logic                           o_busy,
    output logic                           o_md_start,
    output logic [1:0]                     o_md_op,
    output logic                           o_illegal
);

    localparam int MAX_LAT = (MULT_LATENCY > DIV_LATENCY) ? MULT_LATENCY : DIV_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LATENCY - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LATENCY - 1);

    state_t                          state;
    logic [CNT_W-1:0]                cnt;
    logic [ALU_CTRL_BUS_WIDTH-1:0]   md_ctrl;
    logic [ALU_CTRL_BUS_WIDTH-1:0]   dec_ctrl;
    logic                            dec_muldiv;
    logic                            dec_illegal;

    alu_op_decode #(
        .ALU_CTRL_BUS_WIDTH (ALU_CTRL_BUS_WIDTH),
        .ALU_OP_BUS_WIDTH   (ALU_OP_BUS_WIDTH),
        .ALU_FUNCT_BUS_WIDTH(ALU_FUNCT_BUS_WIDTH)
    ) u_decode (
        .alu_op   (i_alu_op),
        .funct    (i_funct),
        .ctrl     (dec_ctrl),
        .is_muldiv(dec_muldiv),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            md_ctrl    <= '0;
            o_alu_ctrl <= '0;
            o_valid    <= 1'b0;
            o_busy     <= 1'b0;
            o_md_start <= 1'b0;
            o_md_op    <= 2'b00;
            o_illegal  <= 1'b0;
        end else if (i_flush) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            o_valid    <= 1'b0;
            o_busy     <= 1'b0;
            o_md_start <= 1'b0;
            o_illegal  <= 1'b0;
        end else begin
            o_md_start <= 1'b0;
            o_illegal  <= 1'b0;
            if (state == ST_MULDIV) begin
                o_valid <= 1'b0;
                if (cnt == '0) begin
                    state      <= ST_DONE;
                    o_busy     <= 1'b0;
                    o_valid    <= 1'b1;
                    o_alu_ctrl <= md_ctrl;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end else begin
                // DONE issues exactly like IDLE so a waiting op goes out with no bubble.
                state   <= ST_IDLE;
                o_valid <= 1'b0;
                if (i_valid) begin
                    if (dec_muldiv) begin
                        state      <= ST_MULDIV;
                        cnt        <= i_funct[1] ? DIV_LOAD : MULT_LOAD;
                        md_ctrl    <= dec_ctrl;
                        o_busy     <= 1'b1;
                        o_md_start <= 1'b1;
                        o_md_op    <= i_funct[1:0];
                    end else if (dec_illegal) begin
                        o_illegal  <= 1'b1;
                        o_alu_ctrl <= '0;
                    end else begin
                        o_valid    <= 1'b1;
                        o_alu_ctrl <= dec_ctrl;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed tables, corner sequences and
// randomized traffic compared against a cycle-count reference model.
module tb_alu_op_sequencer;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_valid;
    logic       i_flush;
    logic [2:0] i_alu_op;
    logic [5:0] i_funct;
    logic [5:0] o_alu_ctrl;
    logic       o_valid;
    logic       o_busy;
    logic       o_md_start;
    logic [1:0] o_md_op;
    logic       o_illegal;

    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    alu_op_sequencer #(
        .ALU_CTRL_BUS_WIDTH (6),
        .ALU_OP_BUS_WIDTH   (3),
        .ALU_FUNCT_BUS_WIDTH(6),
        .MULT_LATENCY       (4),
        .DIV_LATENCY        (32)
    ) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_valid   (i_valid),
        .i_flush   (i_flush),
        .i_alu_op  (i_alu_op),
        .i_funct   (i_funct),
        .o_alu_ctrl(o_alu_ctrl),
        .o_valid   (o_valid),
        .o_busy    (o_busy),
        .o_md_start(o_md_start),
        .o_md_op   (o_md_op),
        .o_illegal (o_illegal)
    );

    // Reference model: remaining busy cycles of the in-flight mult/div op, plus expected outputs.
    int         m_left;
    logic [5:0] m_fn;
    logic       e_valid, e_busy, e_start, e_illegal;
    logic [1:0] e_mdop;
    logic [5:0] e_ctrl;

    function automatic logic [5:0] ref_ctrl(input int op, input int fn);
        case (op)
            0: return 6'd32;
            1: return 6'd34;
            2: return 6'd36;
            3: return 6'd37;
            4: return 6'd38;
            5: return 6'd42;
            6: return 6'(fn);
            default: return 6'd9;
        endcase
    endfunction

    function automatic bit ref_legal(input int fn);
        int ok [16] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 4, 6, 7};
        if (fn / 4 == 6) return 1'b1;
        foreach (ok[k]) if (ok[k] == fn) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_left = 0; m_fn = '0;
        e_valid = 0; e_busy = 0; e_start = 0; e_illegal = 0; e_mdop = 0; e_ctrl = 0;
    endtask

    task automatic model_step(input bit v, input bit f, input int op, input int fn);
        bit trap_on;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        trap_on = 1'b1;
`else
        trap_on = 1'b0;
`endif
        e_start = 0;
        e_illegal = 0;
        if (f) begin
            e_valid = 0; e_busy = 0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            e_valid = 0;
            if (m_left == 0) begin
                e_busy = 0; e_valid = 1; e_ctrl = m_fn;
            end
        end else begin
            e_valid = 0;
            if (v) begin
                if (op == 6 && fn / 4 == 6) begin
                    m_left = (fn % 4 >= 2) ? 32 : 4;
                    m_fn = 6'(fn); e_busy = 1; e_start = 1; e_mdop = 2'(fn % 4);
                end else if (trap_on && op == 6 && !ref_legal(fn)) begin
                    e_illegal = 1; e_ctrl = 0;
                end else begin
                    e_valid = 1; e_ctrl = ref_ctrl(op, fn);
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".valid"},   32'(o_valid),    32'(e_valid));
        chk({tag, ".busy"},    32'(o_busy),     32'(e_busy));
        chk({tag, ".start"},   32'(o_md_start), 32'(e_start));
        chk({tag, ".illegal"}, 32'(o_illegal),  32'(e_illegal));
        if (e_busy)  chk({tag, ".md_op"}, 32'(o_md_op),    32'(e_mdop));
        if (e_valid) chk({tag, ".ctrl"},  32'(o_alu_ctrl), 32'(e_ctrl));
    endtask

    task automatic cycle(input bit v, input bit f, input logic [2:0] op, input logic [5:0] fn,
                         input string tag);
        i_valid = v; i_flush = f; i_alu_op = op; i_funct = fn;
        @(posedge i_clk);
        model_step(v, f, int'(op), int'(fn));
        #1;
        compare_all(tag);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [5:0] fn;
        logic [5:0] ctrl;
    } vec_t;

    vec_t vt [8];

    initial begin
        int busy_cnt;
        bit saw_valid;

        vt[0] = '{3'd0, 6'b011010, 6'b100000};
        vt[1] = '{3'd1, 6'b011010, 6'b100010};
        vt[2] = '{3'd2, 6'b011010, 6'b100100};
        vt[3] = '{3'd3, 6'b011010, 6'b100101};
        vt[4] = '{3'd4, 6'b011010, 6'b100110};
        vt[5] = '{3'd5, 6'b011010, 6'b101010};
        vt[6] = '{3'd6, 6'b100101, 6'b100101};
        vt[7] = '{3'd7, 6'b011010, 6'b001001};

        i_reset = 1; i_valid = 0; i_flush = 0; i_alu_op = '0; i_funct = '0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        compare_all("reset");
        chk("reset.ctrl",  32'(o_alu_ctrl), 0);
        chk("reset.md_op", 32'(o_md_op),    0);
        @(negedge i_clk);
        i_reset = 0;

        // Op-class sweep, back-to-back issue.
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, vt[i].op, vt[i].fn, "sweep");
            chk("sweep_ctrl",  32'(o_alu_ctrl), 32'(vt[i].ctrl));
            chk("sweep_valid", 32'(o_valid),    1);
        end

        // Reset asserted mid-DIV clears everything without waiting for a clock.
        cycle(1, 0, 3'd6, 6'b011011, "divu_pre_rst");
        cycle(0, 0, 3'd0, 6'd0, "divu_busy");
        #2;
        i_reset = 1;
        #1;
        chk("async_rst.valid", 32'(o_valid),    0);
        chk("async_rst.busy",  32'(o_busy),     0);
        chk("async_rst.start", 32'(o_md_start), 0);
        chk("async_rst.ctrl",  32'(o_alu_ctrl), 0);
        chk("async_rst.md_op", 32'(o_md_op),    0);
        model_reset();
        @(negedge i_clk);
        i_reset = 0;
        cycle(1, 0, 3'd0, 6'd0, "post_rst_add");
        chk("post_rst_add_ctrl", 32'(o_alu_ctrl), 32);
        repeat (5) cycle(0, 0, 3'd0, 6'd0, "post_rst_idle");

        // DIV: one start pulse, 32 busy cycles, then the result.
        cycle(1, 0, 3'd6, 6'b011010, "div_issue");
        chk("div_start", 32'(o_md_start), 1);
        chk("div_md_op", 32'(o_md_op),    2);
        busy_cnt = o_busy ? 1 : 0;
        for (int t = 0; t < 60 && o_busy; t++) begin
            cycle(0, 0, 3'd0, 6'd0, "div_wait");
            if (o_busy) busy_cnt++;
        end
        chk("div_busy_len", 32'(busy_cnt),   32);
        chk("div_valid",    32'(o_valid),    1);
        chk("div_ctrl",     32'(o_alu_ctrl), 32'b011010);

        // MULT held on the inputs while busy, then ADD in the DONE cycle.
        cycle(1, 0, 3'd6, 6'b011000, "mult_issue");
        busy_cnt = o_busy ? 1 : 0;
        for (int t = 0; t < 12 && !o_valid; t++) begin
            cycle(1, 0, 3'd6, 6'b011000, "mult_hold");
            if (o_busy) busy_cnt++;
        end
        chk("mult_busy_len", 32'(busy_cnt), 4);
        chk("mult_done",     32'(o_valid),  1);
        cycle(1, 0, 3'd0, 6'd0, "b2b_add");
        chk("b2b_valid", 32'(o_valid),    1);
        chk("b2b_ctrl",  32'(o_alu_ctrl), 32);
        cycle(0, 0, 3'd0, 6'd0, "b2b_idle");

        // Flush in the third busy cycle of a DIV beats a simultaneous i_valid.
        cycle(1, 0, 3'd6, 6'b011010, "div2_issue");
        cycle(0, 0, 3'd0, 6'd0, "div2_b2");
        cycle(0, 0, 3'd0, 6'd0, "div2_b3");
        cycle(1, 1, 3'd0, 6'd0, "flush");
        chk("flush_busy",  32'(o_busy),  0);
        chk("flush_valid", 32'(o_valid), 0);
        saw_valid = 0;
        for (int t = 0; t < 40; t++) begin
            cycle(0, 0, 3'd0, 6'd0, "post_flush");
            if (o_valid) saw_valid = 1;
        end
        chk("flush_no_div_valid", 32'(saw_valid), 0);

        // Undefined funct under alu_op=110.
        cycle(1, 0, 3'd6, 6'b111111, "bad_funct");
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        chk("trap_illegal", 32'(o_illegal), 1);
        chk("trap_valid",   32'(o_valid),   0);
`else
        chk("pass_ctrl",  32'(o_alu_ctrl), 63);
        chk("pass_valid", 32'(o_valid),    1);
`endif

        // Randomized traffic against the model.
        for (int t = 0; t < 600; t++) begin
            bit         rv, rf;
            logic [2:0] rop;
            logic [5:0] rfn;
            rv  = ($urandom_range(0, 9) < 7);
            rf  = ($urandom_range(0, 29) == 0);
            rop = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                rop = 3'd6;
                rfn = {4'b0110, 2'($urandom_range(0, 3))};
            end else begin
                rfn = 6'($urandom_range(0, 63));
            end
            cycle(rv, rf, rop, rfn, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
